// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_DEPTH = 4;
    localparam int WORD_BYTES    = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch word buffer: circular storage with head/tail pointers and an occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            cnt <= cnt + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[tail] <= wdata;
        end
    end

    assign rdata = mem[head];
    assign count = cnt;

endmodule

// File: rtl/imem_fetch.sv
// Instruction prefetch unit: keeps a window of consecutive words ahead of the core's PC
// and redirects the memory stream whenever the PC leaves that window.
module imem_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            PC,
    input  logic                   Advance,
    output logic [31:0]            Instr,
    output logic                   InstrValid,
    output logic                   MemReq,
    output logic [31:0]            MemAddr,
    input  logic                   MemAck,
    input  logic [31:0]            MemRData,
    output fetch_state_t           dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int          CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] STEP = 32'(WORD_BYTES);
    localparam logic [31:0] START_PC = word_align(RESET_PC);

    fetch_state_t  state_q, state_n;
    logic [31:0]   head_addr, head_addr_n;
    logic [31:0]   next_addr, next_addr_n;
    logic [31:0]   req_addr;
    logic [31:0]   pc_aligned;
    logic [31:0]   head_word;
    logic [CW-1:0] count, count_n;
    logic          head_match, hit, mismatch;
    logic          mem_req, ack, push, pop;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (mismatch),
        .wdata (MemRData),
        .rdata (head_word),
        .count (count)
    );

    always_comb begin
        pc_aligned  = word_align(PC);
        head_match  = (pc_aligned == head_addr);
        hit         = !reset && (count != '0) && head_match;
        mismatch    = (count != '0) ? !head_match : (pc_aligned != next_addr);
        mem_req     = (state_q != IDLE);
        ack         = MemAck && mem_req;
        pop         = hit && Advance;
        // Data acked in the cycle of a redirect belongs to the old stream.
        push        = ack && (state_q == FETCH) && !mismatch;
        count_n     = mismatch ? '0
                    : count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        head_addr_n = head_addr;
        next_addr_n = next_addr;
        if (mismatch) begin
            head_addr_n = pc_aligned;
            next_addr_n = pc_aligned;
        end else begin
            if (pop)  head_addr_n = head_addr + STEP;
            if (push) next_addr_n = next_addr + STEP;
        end

        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (count_n < FULL) state_n = FETCH;
            end
            FETCH: begin
                if (mismatch) begin
                    state_n = ack ? FETCH : DISCARD;
                end else if (ack && count_n == FULL) begin
                    state_n = IDLE;
                end
            end
            DISCARD: begin
                if (ack) state_n = FETCH;
            end
            default: state_n = IDLE;
        endcase
    end

    // req_addr only moves when a new request is launched; in DISCARD it holds
    // the address of the transaction still outstanding at the memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            head_addr <= START_PC;
            next_addr <= START_PC;
            req_addr  <= START_PC;
        end else begin
            state_q   <= state_n;
            head_addr <= head_addr_n;
            next_addr <= next_addr_n;
            if (state_n == FETCH) begin
                req_addr <= next_addr_n;
            end
        end
    end

    assign InstrValid = hit;
    assign Instr      = hit ? head_word : 32'h0;
    assign MemReq     = mem_req;
    assign MemAddr    = req_addr;
    assign dbg_state  = state_q;
    assign dbg_count  = count;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: fill, streaming, redirects, reset abort and address wrap.
module tb_imem_fetch;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         reset, advance, mem_ack;
    logic [31:0]  pc, mem_rdata;
    logic [31:0]  instr, mem_addr;
    logic         instr_valid, mem_req;
    fetch_state_t state;
    logic [2:0]   count;

    logic         w_reset, w_advance, w_ack;
    logic [31:0]  w_pc, w_rdata;
    logic [31:0]  w_instr, w_mem_addr;
    logic         w_instr_valid, w_mem_req;
    fetch_state_t w_state;
    logic [2:0]   w_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imem_fetch dut (
        .clk(clk), .reset(reset), .PC(pc), .Advance(advance),
        .Instr(instr), .InstrValid(instr_valid), .MemReq(mem_req), .MemAddr(mem_addr),
        .MemAck(mem_ack), .MemRData(mem_rdata), .dbg_state(state), .dbg_count(count)
    );

    imem_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(w_reset), .PC(w_pc), .Advance(w_advance),
        .Instr(w_instr), .InstrValid(w_instr_valid), .MemReq(w_mem_req), .MemAddr(w_mem_addr),
        .MemAck(w_ack), .MemRData(w_rdata), .dbg_state(w_state), .dbg_count(w_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic a, input logic ack, input logic [31:0] d);
        pc        = p;
        advance   = a;
        mem_ack   = ack;
        mem_rdata = d;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w_reset = 1'b1; w_advance = 1'b0; w_ack = 1'b0;
        w_pc = 32'hFFFF_FFF8; w_rdata = 32'h0;

        // Reset and initial fill
        do_reset();
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(32'h0, 1'b0, 1'b0, 32'h0);
            check("fill_req", 32'(mem_req), 32'd1);
            check("fill_addr", mem_addr, 32'(4 * i));
            tick();
            drive(32'h0, 1'b0, 1'b1, 32'hE0 + 32'(i));
            tick();
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        check("full_memreq", 32'(mem_req), 32'd0);
        check("full_count", 32'(count), 32'd4);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_instr", instr, 32'hE0);

        // Streaming: pop every cycle, memory answers the same cycle it sees MemReq
        for (int k = 0; k < 8; k++) exp_q.push_back(32'hE0 + 32'(k));
        for (int k = 0; k < 8; k++) begin
            if (k == 0) drive(32'h0, 1'b1, 1'b1, 32'h55);
            else        drive(32'(4 * k), 1'b1, 1'b1, 32'hE0 + 32'(3 + k));
            check("strm_valid", 32'(instr_valid), 32'd1);
            check("strm_instr", instr, exp_q.pop_front());
            check("strm_count", 32'(count), (k == 0) ? 32'd4 : 32'd3);
            if (k == 0) check("strm_req0", 32'(mem_req), 32'd0);
            else begin
                check("strm_req", 32'(mem_req), 32'd1);
                check("strm_addr", mem_addr, 32'(12 + 4 * k));
            end
            tick();
        end

        // Redirect while a request is outstanding
        do_reset();
        drive(32'h8, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'h8, 1'b0, 1'b0, 32'h0);
        check("b_addr8", mem_addr, 32'h8);
        tick();
        drive(32'h40, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'h40, 1'b1, 1'b0, 32'h0);
        check("b_discard", 32'(state), 32'(DISCARD));
        check("b_hold_addr", mem_addr, 32'h8);
        check("b_hold_req", 32'(mem_req), 32'd1);
        tick();
        drive(32'h40, 1'b0, 1'b0, 32'h0);
        check("b_adv_ignored", 32'(count), 32'd0);
        tick();
        drive(32'h40, 1'b0, 1'b1, 32'hBAD);
        tick();
        drive(32'h40, 1'b0, 1'b1, 32'hC40);
        check("b_dropped", 32'(instr_valid), 32'd0);
        check("b_new_addr", mem_addr, 32'h40);
        check("b_fetch", 32'(state), 32'(FETCH));
        tick();
        drive(32'h40, 1'b0, 1'b0, 32'h0);
        check("b_valid", 32'(instr_valid), 32'd1);
        check("b_instr", instr, 32'hC40);
        tick();

        // Redirect coincident with an ack
        drive(32'h100, 1'b0, 1'b1, 32'hDEAD);
        check("c_miss", 32'(instr_valid), 32'd0);
        tick();
        drive(32'h100, 1'b0, 1'b1, 32'hC100);
        check("c_state", 32'(state), 32'(FETCH));
        check("c_addr", mem_addr, 32'h100);
        check("c_count", 32'(count), 32'd0);
        tick();
        drive(32'h100, 1'b0, 1'b0, 32'h0);
        check("c_valid", 32'(instr_valid), 32'd1);
        check("c_instr", instr, 32'hC100);
        check("c_next_addr", mem_addr, 32'h104);
        tick();

        // Reset mid-request with a coincident ack
        reset = 1'b1;
        drive(32'h100, 1'b0, 1'b1, 32'h777);
        check("r_valid_in_reset", 32'(instr_valid), 32'd0);
        tick();
        reset = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        check("r_memreq", 32'(mem_req), 32'd0);
        check("r_count", 32'(count), 32'd0);
        check("r_state", 32'(state), 32'(IDLE));
        check("r_valid", 32'(instr_valid), 32'd0);
        tick();
        check("r_restart_addr", mem_addr, 32'h0);

        // Address wrap from RESET_PC = FFFF_FFF8
        tick();
        w_reset = 1'b0;
        #1;
        check("w_idle", 32'(w_state), 32'(IDLE));
        tick();
        for (int i = 0; i < 3; i++) begin
            w_ack = 1'b1;
            w_rdata = 32'hA0 + 32'(i);
            #1;
            check("w_req", 32'(w_mem_req), 32'd1);
            check("w_addr", w_mem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            tick();
        end
        w_ack = 1'b0;
        #1;
        check("w_count", 32'(w_count), 32'd3);
        check("w_instr", w_instr, 32'hA0);
        check("w_addr_next", w_mem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch buffer entries; power of 2, >= 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk edge only.
REQ-005 PC  input  32  core's current fetch address; bits [1:0] ignored.
REQ-006 Advance  input  1  core retires the presented instruction this cycle.
REQ-007 Instr  output  32  instruction word for PC; 32'h0 when InstrValid=0.
REQ-008 InstrValid  output  1  Instr is valid for PC this cycle (combinational from state and PC).
REQ-009 MemReq  output  1  registered request to instruction memory.
REQ-010 MemAddr  output  32  word-aligned request address; stable while MemReq=1 and no MemAck.
REQ-011 MemAck  input  1  memory returns MemRData for MemAddr this cycle; ignored when MemReq=0.
REQ-012 MemRData  input  32  read data, valid with MemAck.

Function
REQ-013 Buffer SHALL hold up to DEPTH consecutive words; head word address HeadAddr, next fetch address NextAddr = HeadAddr + 4*count.
REQ-014 Hit = count>0 and PC[31:2]==HeadAddr[31:2]; InstrValid=Hit; Instr=head word on hit.
REQ-015 Pop on Hit and Advance: head pointer +1 mod DEPTH, HeadAddr +4, count -1.
REQ-016 Advance with InstrValid=0 SHALL be ignored.
REQ-017 Mismatch = (count>0 and PC[31:2]!=HeadAddr[31:2]) or (count==0 and PC[31:2]!=NextAddr[31:2]).
REQ-018 On mismatch: count<=0, HeadAddr<=NextAddr<={PC[31:2],2'b00}; same-cycle MemAck data discarded.
REQ-019 FSM states IDLE, FETCH, DISCARD.
REQ-020 IDLE: MemReq=0; -> FETCH when count<DEPTH (after pop/flush of this cycle).
REQ-021 FETCH: MemReq=1, MemAddr=NextAddr; on MemAck (no mismatch) push MemRData at tail, NextAddr +4; -> IDLE if resulting count==DEPTH, else stay FETCH with new MemAddr next cycle.
REQ-022 Mismatch in FETCH without same-cycle MemAck -> DISCARD, keeping MemReq=1 and old MemAddr.
REQ-023 DISCARD: on MemAck drop data, -> FETCH at NextAddr; further mismatches in DISCARD only update NextAddr.
REQ-024 Mismatch in FETCH with same-cycle MemAck -> FETCH at new address next cycle.
REQ-025 Simultaneous pop and push: count unchanged; full buffer with pop in same cycle SHALL re-enter FETCH next cycle.
REQ-026 Address arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 Latency: MemAck in cycle a for address == PC yields InstrValid=1 in cycle a+1; miss in cycle t issues MemReq for PC in cycle t+1 (unless DISCARD).
REQ-028 count SHALL never exceed DEPTH nor underflow.

Reset
REQ-029 During reset: state IDLE, count 0, head/tail pointers 0, HeadAddr=NextAddr=RESET_PC, MemReq=0, InstrValid=0, Instr=0.
REQ-030 Reset mid-request SHALL abandon the transaction; MemAck seen in the reset cycle is ignored.
REQ-031 First cycle after reset: IDLE -> FETCH; MemReq=1, MemAddr=RESET_PC one cycle later.
REQ-032 Buffer storage contents need not be reset.

Structure
REQ-033 Package fetch_pkg: state enum (IDLE, FETCH, DISCARD), DEPTH default, WORD_BYTES=4.
REQ-034 Sub-module fetch_fifo: DEPTH x 32 storage with head/tail pointers, push/pop/flush, count output; FSM and address logic stay in imem_fetch.

Verification
REQ-035 Reset, PC=0, MemAck one cycle after each MemReq, data 0xE0,0xE1,... -> MemAddr 0,4,8,12; InstrValid=1 for PC=0 with Instr=0xE0; MemReq drops after 4 entries with no Advance.
REQ-036 Buffer full, Advance each cycle with PC +4 -> InstrValid held 1, Instr sequential, count never exceeds 4, MemReq re-asserts the cycle after first pop.
REQ-037 PC jumps 0x8 -> 0x40 while MemReq pending, MemAck 3 cycles later -> that data discarded (InstrValid=0), next MemAddr=0x40, Instr correct one cycle after its ack.
REQ-038 Redirect coincident with MemAck -> acked data dropped, MemAddr=new PC next cycle, no DISCARD state.
REQ-039 RESET_PC=32'hFFFF_FFF8, sequential fetch -> MemAddr FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 Reset asserted with MemReq=1 and MemAck=1 same cycle -> MemReq=0, count=0, data not buffered.
